// File: rtl/adder_mul_sequencer.sv
// Shift-and-add multiplier controller driving the shared ripple adder.
// Optional early termination when the remaining multiplier bits are zero: ADDER_MUL_EARLY_TERM_EN.
module adder_mul_sequencer #(
    parameter int OP_WIDTH  = 4,
    parameter int ACC_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    input  logic [OP_WIDTH-1:0]  i_a,
    input  logic [OP_WIDTH-1:0]  i_b,
    output logic [ACC_WIDTH-1:0] o_add_a,
    output logic [ACC_WIDTH-1:0] o_add_b,
    input  logic [ACC_WIDTH-1:0] i_add_s,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [ACC_WIDTH-1:0] o_product
);
    localparam int CNT_W = (OP_WIDTH > 1) ? $clog2(OP_WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

    state_t               r_state, w_next;
    logic [ACC_WIDTH-1:0] r_acc, r_mcand, r_product;
    logic [OP_WIDTH-1:0]  r_mplier;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_accept, w_iter, w_last;

    assign w_iter   = (r_state == S_ITER);
    assign w_accept = i_start && (r_state == S_IDLE || r_state == S_DONE);

`ifdef ADDER_MUL_EARLY_TERM_EN
    // Stop as soon as no set multiplier bits remain after this step.
    assign w_last = w_iter && ((r_cnt == CNT_W'(OP_WIDTH-1)) || ((r_mplier >> 1) == '0));
`else
    assign w_last = w_iter && (r_cnt == CNT_W'(OP_WIDTH-1));
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_ITER;
            S_ITER:  if (w_last)   w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_ITER : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_mcand  <= ACC_WIDTH'(i_a);
                r_mplier <= i_b;
                r_acc    <= '0;
                r_cnt    <= '0;
            end else if (w_iter) begin
                r_acc    <= i_add_s;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
                // Final sum goes straight to the product so it is valid in the DONE cycle.
                if (w_last) r_product <= i_add_s;
            end
        end
    end

    assign o_add_a   = w_iter ? r_acc : '0;
    assign o_add_b   = (w_iter && r_mplier[0]) ? r_mcand : '0;
    assign o_busy    = w_iter;
    assign o_done    = (r_state == S_DONE);
    assign o_product = r_product;
endmodule

// File: tb/tb_adder_mul_sequencer.sv
// Scoreboard bench for adder_mul_sequencer; models the external adder as A+B.
module tb_adder_mul_sequencer;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       start = 0;
    logic [3:0] a = 0, b = 0;
    logic [7:0] add_a, add_b, add_s, product;
    logic       busy, done;

    adder_mul_sequencer #(.OP_WIDTH(4), .ACC_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b),
        .o_add_a(add_a), .o_add_b(add_b), .i_add_s(add_s),
        .o_busy(busy), .o_done(done), .o_product(product)
    );

    assign add_s = add_a + add_b;
    always #5 clk = ~clk;

    typedef struct { int prod; int cyc; } exp_t;
    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0, fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int iters(input logic [3:0] bv);
`ifdef ADDER_MUL_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < 4; i++) if (bv[i]) n = i + 1;
        return n;
`else
        return 4;
`endif
    endfunction

    // Monitor: every Done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("product", int'(product), e.prod);
                check("done_cycle", cyc, e.cyc);
            end
        end
    end

    // Drive Start for one edge; the request is expected to be accepted.
    task automatic issue(input logic [3:0] av, input logic [3:0] bv);
        exp_t e;
        start = 1; a = av; b = bv;
        @(posedge clk); #1;
        e.prod = int'(av) * int'(bv);
        e.cyc  = cyc + iters(bv);
        exp_q.push_back(e);
        start = 0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        if (!done) check({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        logic [7:0] seq_a [4];
        logic [7:0] seq_b [4];
        int nb, it;
        seq_a = '{8'd0, 8'd3, 8'd3, 8'd15};
        seq_b = '{8'd3, 8'd0, 8'd12, 8'd0};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_product", product, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        @(negedge clk); rst_n = 1;
        @(negedge clk);

        // 15x15: busy length and product hold
        issue(4'd15, 4'd15);
        nb = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy) nb++;
        end
        check("busy_cycles_15x15", nb, iters(4'd15));
        repeat (3) @(negedge clk);
        check("product_hold", product, 225);
        check("idle_busy", busy, 0);

        // 3x5: adder operand sequence
        issue(4'd3, 4'd5);
        it = iters(4'd5);
        for (int i = 0; i < it; i++) begin
            @(negedge clk);
            check($sformatf("add_a[%0d]", i), add_a, seq_a[i]);
            check($sformatf("add_b[%0d]", i), add_b, seq_b[i]);
        end
        wait_done("3x5");
        @(negedge clk);

        // 9x0: zero multiplier
        issue(4'd9, 4'd0);
        for (int i = 0; i < iters(4'd0); i++) begin
            @(negedge clk);
            check("add_b_zero", add_b, 0);
        end
        wait_done("9x0");
        @(negedge clk);

        // 7x6 with a Start while busy, then back-to-back 2x3 in the DONE cycle
        issue(4'd7, 4'd6);
        @(negedge clk);
        start = 1; a = 4'd1; b = 4'd1;
        @(negedge clk);
        start = 0; a = 4'd0; b = 4'd0;
        wait_done("7x6");
        issue(4'd2, 4'd3);
        @(negedge clk);
        check("b2b_busy", busy, 1);
        wait_done("2x3");
        @(negedge clk);

        // Reset in the 2nd ITER cycle aborts without Done
        issue(4'd15, 4'd15);
        @(negedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        void'(exp_q.pop_back());
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_product", product, 0);
        @(negedge clk); rst_n = 1;
        repeat (6) @(negedge clk);
        check("post_abort_idle", busy, 0);

        // Early-termination cases (fixed latency when the feature is off)
        issue(4'd7, 4'd1);
        wait_done("7x1");
        @(negedge clk);
        issue(4'd7, 4'd8);
        wait_done("7x8");
        repeat (2) @(negedge clk);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
